// File: rtl/fifo_ser_pkg.sv
// Shared definitions for the FIFO-draining serial transmitter.
package fifo_ser_pkg;

  localparam int unsigned WORD_W     = 20;
  localparam int unsigned FRAME_BITS = WORD_W + 3;
  localparam int unsigned BIT_CNT_W  = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_serializer_baud_tick.sv
// Bit-period divider: tick marks the last clock of each serial bit.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_next_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // tick is registered from the next count so it lines up with count == LAST
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
    tick_d = !clear && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick        = tick_q;
  assign tick_next_c = tick_d;

endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a FIFO and sends each as start + LSB-first data + even parity + stop.
module fifo_serializer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned WORD_W       = fifo_ser_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  input  logic [WORD_W-1:0] fifo_data,
  output logic              read,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  import fifo_ser_pkg::*;

  localparam int unsigned BW = BIT_CNT_W;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear_c;
  logic              tick;
  logic              tick_next_c;

  // Divider is held at zero outside the timed line states
  assign clear_c = (state_q == S_IDLE) || (state_q == S_POP) || (state_q == S_LOAD);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_c),
    .tick       (tick),
    .tick_next_c(tick_next_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;

    case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_POP;
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d   = fifo_data;
        parity_d  = ^fifo_data;
        bit_cnt_d = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BW'(WORD_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops line up with state_q
    read_d = (state_d == S_POP);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && tick_next_c;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign read = read_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
